fft_frame_collector: RTL and testbench
======================================

Name: fft_frame_collector

Overview:
- AXI4-Stream sink for the FFT core's result stream: 48-bit complex bins, tuser bin index, tlast frame marker.
- Collects each complete frame into one half of an internal ping-pong buffer. Validates the frame length. Hands finished frames to the power/dB pipeline through a random-access read port.
- Applies tready backpressure to the FFT when both banks are occupied.
- Sits between the FFT output and the power calculator. Replaces ad-hoc result capture in the control FSM.

Parameters:
- POINTS, 1024, bins per frame.
- ADDR_W, 10, bin index width; equals log2(POINTS).
- DATA_W, 48, bin width: imag in [47:24], real in [23:0].
- USER_W, 24, tuser width; bin index taken from tuser[ADDR_W-1:0].

Ports:
- clk  in  1  system clock (24 MHz domain).
- rst_n  in  1  asynchronous active-low reset.
- s_axis_tdata  in  DATA_W  FFT bin data.
- s_axis_tvalid  in  1  bin valid.
- s_axis_tready  out  1  sink ready.
- s_axis_tlast  in  1  last bin of frame.
- s_axis_tuser  in  USER_W  bin index in low ADDR_W bits.
- frame_ready  out  1  a complete frame is readable.
- frame_release  in  1  single-cycle pulse: consumer done with the current frame.
- rd_en  in  1  read strobe.
- rd_addr  in  ADDR_W  bin address to read.
- rd_data  out  DATA_W  registered read data.
- rd_valid  out  1  rd_data valid; rd_en delayed by 1 cycle.
- frame_cnt  out  16  count of released frames; wraps at 65535->0.
- err_len  out  1  1-cycle pulse: tlast arrived before POINTS beats.
- err_last  out  1  1-cycle pulse: POINTS-th beat arrived without tlast.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values:
  - s_axis_tready=0 while rst_n=0, then 1 from the first clk edge after release.
  - frame_ready=0, rd_data=0, rd_valid=0, frame_cnt=0, err_len=0, err_last=0.
  - wr_sel=0, rd_sel=0, bank_full=2'b00, beat_cnt=0, state=S_COLLECT.
  - RAM contents are not reset.
- Storage: two banks of POINTS x DATA_W, wr_sel and rd_sel select the bank. Handshake = tvalid & tready.
- Write FSM:
  - S_COLLECT:
    - tready = !bank_full[wr_sel].
    - Each handshake writes tdata to bank[wr_sel][tuser[ADDR_W-1:0]] and increments beat_cnt.
    - Handshake with tlast=1 and beat_cnt==POINTS-1: set bank_full[wr_sel], toggle wr_sel, beat_cnt=0.
    - Handshake with tlast=1 and beat_cnt<POINTS-1: pulse err_len, bank not marked, beat_cnt=0. Bank contents are overwritten by the next frame.
    - Handshake with tlast=0 and beat_cnt==POINTS-1: pulse err_last, go to S_DRAIN.
  - S_DRAIN:
    - tready=1, beats discarded (no RAM write).
    - Handshake with tlast=1: beat_cnt=0, go to S_COLLECT.
- Read side:
  - frame_ready = bank_full[rd_sel], registered.
  - frame_release while frame_ready=1: clear bank_full[rd_sel], toggle rd_sel, frame_cnt+1. frame_ready falls on the next cycle.
  - frame_release while frame_ready=0: ignored.
  - rd_en=1: rd_data <= bank[rd_sel][rd_addr] on the next edge; rd_valid=1 on that cycle. rd_data holds its value when rd_en=0.
  - Reads are allowed regardless of frame_ready; data is undefined when the bank is not full.
- Backpressure: when both banks are full, tready=0 in S_COLLECT until a release. Release and the completing write in the same cycle cannot touch the same bank. Both take effect; tready rises the cycle after the release.
- Index handling: the tuser index is used as-is (bit-reversed or natural order both supported). Duplicate indices overwrite; no check.
- Latency: last beat handshake to frame_ready=1 is 2 cycles, when rd_sel already points to that bank.
- Reset mid-frame: partial frame discarded, all state returns to reset values, err pulses suppressed.

Test Plan:
- 1024 beats with tuser=0..1023 and tdata=index, tlast on beat 1023 -> frame_ready=1 two cycles later; rd_addr=5 returns 48'd5 with rd_valid one cycle after rd_en.
- Bit-reversed tuser order (tuser=bitrev10(n), tdata=n) -> rd_addr=bitrev10(n) returns n for all 1024 bins.
- Three back-to-back frames, no release -> frames 0 and 1 stored; tready=0 at frame 2 beat 0; one frame_release -> frame_cnt=1, tready=1 next cycle, frame 2 lands in bank 0.
- tlast on beat 500 -> err_len pulses once, frame_ready stays 0; next full frame -> frame_ready=1.
- 1030 beats, tlast on beat 1029 -> err_last at beat 1023, beats 1024-1029 accepted and discarded, no frame_ready; following good frame accepted.
- rst_n low at beat 300 of frame 1 while frame 0 is full -> all outputs return to reset values within the asynchronous assertion; next frame lands in bank 0; frame_cnt=0.

Source files
------------

// File: rtl/fft_frame_collector.sv
// AXI4-Stream sink that gathers FFT result frames into a ping-pong buffer.
// Finished frames are exposed through a registered random-access read port.
//
//  state     | meaning
//  S_COLLECT | accepting beats into bank[wr_sel], stalls while that bank is full
//  S_DRAIN   | overlong frame, discarding beats until tlast
module fft_frame_collector #(
    parameter int POINTS = 1024,
    parameter int ADDR_W = 10,
    parameter int DATA_W = 48,
    parameter int USER_W = 24
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] s_axis_tdata,
    input  logic              s_axis_tvalid,
    output logic              s_axis_tready,
    input  logic              s_axis_tlast,
    input  logic [USER_W-1:0] s_axis_tuser,
    output logic              frame_ready,
    input  logic              frame_release,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic [15:0]       frame_cnt,
    output logic              err_len,
    output logic              err_last
);

    typedef enum logic {S_COLLECT, S_DRAIN} state_t;

    localparam logic [ADDR_W-1:0] LAST_BEAT = ADDR_W'(POINTS - 1);

    state_t            state, state_nxt;
    logic              wr_sel, wr_sel_nxt;
    logic              rd_sel;
    logic              out_of_rst;
    logic [1:0]        bank_full, bank_full_nxt;
    logic [ADDR_W-1:0] beat_cnt, beat_cnt_nxt;
    logic              ready;
    logic              wr_en;
    logic              release_ok;
    logic              err_len_nxt, err_last_nxt;
    logic              unused_user;

    logic [DATA_W-1:0] mem [2*POINTS];

    assign unused_user   = ^s_axis_tuser[USER_W-1:ADDR_W];
    assign s_axis_tready = ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_COLLECT;
            wr_sel     <= 1'b0;
            bank_full  <= 2'b00;
            beat_cnt   <= '0;
            err_len    <= 1'b0;
            err_last   <= 1'b0;
            out_of_rst <= 1'b0;
        end else begin
            state      <= state_nxt;
            wr_sel     <= wr_sel_nxt;
            bank_full  <= bank_full_nxt;
            beat_cnt   <= beat_cnt_nxt;
            err_len    <= err_len_nxt;
            err_last   <= err_last_nxt;
            out_of_rst <= 1'b1;
        end
    end

    always_comb begin
        state_nxt     = state;
        wr_sel_nxt    = wr_sel;
        bank_full_nxt = bank_full;
        beat_cnt_nxt  = beat_cnt;
        err_len_nxt   = 1'b0;
        err_last_nxt  = 1'b0;
        wr_en         = 1'b0;
        ready         = 1'b0;
        release_ok    = frame_release & frame_ready;

        // A release can only hit a full bank and a completion only a non-full
        // one, so both updates apply without conflict.
        if (release_ok)
            bank_full_nxt[rd_sel] = 1'b0;

        case (state)
            S_COLLECT: begin
                ready = out_of_rst & ~bank_full[wr_sel];
                if (s_axis_tvalid && ready) begin
                    wr_en        = 1'b1;
                    beat_cnt_nxt = beat_cnt + 1'b1;
                    if (s_axis_tlast) begin
                        beat_cnt_nxt = '0;
                        if (beat_cnt == LAST_BEAT) begin
                            bank_full_nxt[wr_sel] = 1'b1;
                            wr_sel_nxt            = ~wr_sel;
                        end else begin
                            err_len_nxt = 1'b1;
                        end
                    end else if (beat_cnt == LAST_BEAT) begin
                        err_last_nxt = 1'b1;
                        beat_cnt_nxt = '0;
                        state_nxt    = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                ready = out_of_rst;
                if (s_axis_tvalid && ready && s_axis_tlast) begin
                    beat_cnt_nxt = '0;
                    state_nxt    = S_COLLECT;
                end
            end
            default: state_nxt = S_COLLECT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[{wr_sel, s_axis_tuser[ADDR_W-1:0]}] <= s_axis_tdata;
    end

    // frame_ready drops in the cycle after a release even if the other bank
    // is already full, so one pulse can never retire two frames.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_sel      <= 1'b0;
            frame_ready <= 1'b0;
            frame_cnt   <= '0;
            rd_data     <= '0;
            rd_valid    <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en)
                rd_data <= mem[{rd_sel, rd_addr}];
            if (release_ok) begin
                rd_sel      <= ~rd_sel;
                frame_cnt   <= frame_cnt + 16'd1;
                frame_ready <= 1'b0;
            end else begin
                frame_ready <= bank_full[rd_sel];
            end
        end
    end

endmodule

// File: tb/tb_fft_frame_collector.sv
// Directed bench for fft_frame_collector: frame capture, ping-pong backpressure,
// length errors and mid-frame reset, checked with immediate assertions.
module tb_fft_frame_collector;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [47:0] s_axis_tdata;
    logic        s_axis_tvalid;
    logic        s_axis_tready;
    logic        s_axis_tlast;
    logic [23:0] s_axis_tuser;
    logic        frame_ready;
    logic        frame_release;
    logic        rd_en;
    logic [9:0]  rd_addr;
    logic [47:0] rd_data;
    logic        rd_valid;
    logic [15:0] frame_cnt;
    logic        err_len;
    logic        err_last;

    int n_checks = 0;
    int n_pass   = 0;

    fft_frame_collector dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tuser  (s_axis_tuser),
        .frame_ready   (frame_ready),
        .frame_release (frame_release),
        .rd_en         (rd_en),
        .rd_addr       (rd_addr),
        .rd_data       (rd_data),
        .rd_valid      (rd_valid),
        .frame_cnt     (frame_cnt),
        .err_len       (err_len),
        .err_last      (err_last)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    function automatic logic [9:0] bitrev10(input logic [9:0] v);
        logic [9:0] r;
        for (int b = 0; b < 10; b++) r[b] = v[9-b];
        return r;
    endfunction

    task automatic send_beat(input logic [47:0] d, input logic [9:0] u, input logic l);
        int waitc;
        waitc         = 0;
        s_axis_tdata  = d;
        s_axis_tuser  = {14'd0, u};
        s_axis_tlast  = l;
        s_axis_tvalid = 1'b1;
        while (!s_axis_tready && waitc < 3000) begin
            step();
            waitc++;
        end
        if (waitc >= 3000) begin
            n_checks++;
            $error("FAIL tready_timeout: observed 0 expected 1");
        end
        step();
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    task automatic send_range(input int lo, input int hi, input int last_at,
                              input int offset, input logic brev);
        for (int i = lo; i <= hi; i++)
            send_beat(48'(i + offset), brev ? bitrev10(10'(i)) : 10'(i), i == last_at);
    endtask

    task automatic do_read(input logic [9:0] addr, input logic [47:0] exp, input string tag);
        rd_en   = 1'b1;
        rd_addr = addr;
        step();
        rd_en   = 1'b0;
        check({tag, "_valid"}, 64'(rd_valid), 64'd1);
        check(tag, 64'(rd_data), 64'(exp));
    endtask

    task automatic pulse_release();
        frame_release = 1'b1;
        step();
        frame_release = 1'b0;
    endtask

    initial begin
        rst_n         = 1'b0;
        s_axis_tdata  = '0;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        s_axis_tuser  = '0;
        frame_release = 1'b0;
        rd_en         = 1'b0;
        rd_addr       = '0;
        repeat (3) step();

        check("rst_tready",   64'(s_axis_tready), 64'd0);
        check("rst_fready",   64'(frame_ready),   64'd0);
        check("rst_rd_data",  64'(rd_data),       64'd0);
        check("rst_rd_valid", 64'(rd_valid),      64'd0);
        check("rst_fcnt",     64'(frame_cnt),     64'd0);
        check("rst_err_len",  64'(err_len),       64'd0);
        check("rst_err_last", 64'(err_last),      64'd0);
        rst_n = 1'b1;
        step();
        check("tready_after_rst", 64'(s_axis_tready), 64'd1);

        // frame A: natural order into bank 0
        send_range(0, 1023, 1023, 0, 1'b0);
        check("a_lat1", 64'(frame_ready), 64'd0);
        step();
        check("a_lat2", 64'(frame_ready), 64'd1);
        check("a_rdv_idle", 64'(rd_valid), 64'd0);
        do_read(10'd5, 48'd5, "a_rd5");
        step();
        check("a_rdv_drop", 64'(rd_valid), 64'd0);
        check("a_rd_hold",  64'(rd_data),  64'd5);

        // frame B: bit-reversed order into bank 1, buffer now full
        send_range(0, 1023, 1023, 0, 1'b1);
        for (int k = 0; k < 3; k++) begin
            check("full_tready", 64'(s_axis_tready), 64'd0);
            step();
        end
        check("full_fcnt", 64'(frame_cnt), 64'd0);
        pulse_release();
        check("relA_fcnt",   64'(frame_cnt),     64'd1);
        check("relA_fready", 64'(frame_ready),   64'd0);
        check("relA_tready", 64'(s_axis_tready), 64'd1);
        step();
        check("b_fready", 64'(frame_ready), 64'd1);
        for (int n = 0; n < 1024; n++)
            do_read(bitrev10(10'(n)), 48'(n), "b_bitrev");

        // frame C lands in bank 0
        send_range(0, 1023, 1023, 2000, 1'b0);
        check("c_fready_b", 64'(frame_ready), 64'd1);
        pulse_release();
        check("relB_fcnt",   64'(frame_cnt),   64'd2);
        check("relB_fready", 64'(frame_ready), 64'd0);
        step();
        check("c_fready", 64'(frame_ready), 64'd1);
        do_read(10'd7, 48'd2007, "c_rd7");
        pulse_release();
        check("relC_fcnt", 64'(frame_cnt), 64'd3);
        step();
        check("empty_fready", 64'(frame_ready), 64'd0);
        pulse_release();
        check("ignored_rel_fcnt", 64'(frame_cnt), 64'd3);

        // short frame: tlast on beat 500
        send_range(0, 500, 500, 3000, 1'b0);
        check("short_err_len", 64'(err_len), 64'd1);
        step();
        check("short_err_len_drop", 64'(err_len),     64'd0);
        check("short_fready",       64'(frame_ready), 64'd0);
        send_range(0, 1023, 1023, 3000, 1'b0);
        check("d_lat1", 64'(frame_ready), 64'd0);
        check("d_err_len", 64'(err_len), 64'd0);
        step();
        check("d_lat2", 64'(frame_ready), 64'd1);
        do_read(10'd500,  48'd3500, "d_rd500");
        do_read(10'd1023, 48'd4023, "d_rd1023");
        pulse_release();
        check("relD_fcnt", 64'(frame_cnt), 64'd4);

        // long frame: 1030 beats, tlast on beat 1029
        send_range(0, 1023, -1, 5000, 1'b0);
        check("long_err_last", 64'(err_last),      64'd1);
        check("drain_tready",  64'(s_axis_tready), 64'd1);
        send_range(1024, 1029, 1029, 5000, 1'b0);
        check("long_err_last_drop", 64'(err_last), 64'd0);
        step();
        step();
        check("long_fready", 64'(frame_ready), 64'd0);
        send_range(0, 1023, 1023, 7000, 1'b0);
        check("e_lat1", 64'(frame_ready), 64'd0);
        step();
        check("e_lat2", 64'(frame_ready), 64'd1);
        do_read(10'd3, 48'd7003, "e_rd3");

        // reset mid-frame while bank 0 is full
        send_range(0, 299, -1, 9000, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check("mrst_tready",   64'(s_axis_tready), 64'd0);
        check("mrst_fready",   64'(frame_ready),   64'd0);
        check("mrst_rd_data",  64'(rd_data),       64'd0);
        check("mrst_rd_valid", 64'(rd_valid),      64'd0);
        check("mrst_fcnt",     64'(frame_cnt),     64'd0);
        check("mrst_err_len",  64'(err_len),       64'd0);
        check("mrst_err_last", 64'(err_last),      64'd0);
        step();
        step();
        rst_n = 1'b1;
        step();
        check("mrst_tready_up", 64'(s_axis_tready), 64'd1);
        send_range(0, 1023, 1023, 11000, 1'b0);
        check("f_lat1", 64'(frame_ready), 64'd0);
        step();
        check("f_lat2", 64'(frame_ready), 64'd1);
        do_read(10'd9, 48'd11009, "f_rd9");
        check("f_fcnt", 64'(frame_cnt), 64'd0);
        pulse_release();
        check("relF_fcnt", 64'(frame_cnt), 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
